// File: rtl/ysyx_22040931_jump_unit_pkg.sv
// Shared encodings for the jump unit: opcodes, ALU/EX operation codes and the
// registered control bundle.
package ysyx_22040931_jump_unit_pkg;

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [4:0] {
    ALU_NONE  = 5'd0,
    ALU_ARITH = 5'd1
  } aluop_e;

  typedef enum logic [2:0] {
    EX_NONE   = 3'd0,
    EX_JUMP   = 3'd1,
    EX_BRANCH = 3'd2
  } exop_e;

  typedef struct packed {
    logic   jump;
    logic   jtype;
    logic   btype;
    aluop_e aluop;
    exop_e  exop;
  } ctrl_t;

  // x1 (ra) and x5 (t0) are the calling-convention link registers.
  function automatic logic is_link_reg(input logic [4:0] r);
    return (r == 5'd1) || (r == 5'd5);
  endfunction

endpackage

// File: rtl/ysyx_22040931_jump_unit_if.sv
// Decode-side and EXU/IFU-side signals of the jump unit, with a driver (master)
// view and a unit (slave) view.
interface ysyx_22040931_jump_unit_if #(
  parameter int XLEN      = 64,
  parameter int RAS_DEPTH = 4,
  parameter int CNT_W     = 16
);
  localparam int CW = $clog2(RAS_DEPTH) + 1;

  logic            in_valid;
  logic            in_ready;
  logic [6:0]      opcode;
  logic [4:0]      rd;
  logic [4:0]      rs1;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] rs1_data;
  logic            br_taken;
  logic            out_valid;
  logic            out_ready;
  logic            jump;
  logic            jtype;
  logic            btype;
  logic [4:0]      aluop;
  logic [2:0]      exop;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] link_pc;
  logic [XLEN-1:0] ras_pred;
  logic            ras_hit;
  logic [CW-1:0]   ras_cnt;
  logic [CNT_W-1:0] miss_cnt;

  modport master (
    output in_valid, opcode, rd, rs1, pc, imm, rs1_data, br_taken, out_ready,
    input  in_ready, out_valid, jump, jtype, btype, aluop, exop, target,
           link_pc, ras_pred, ras_hit, ras_cnt, miss_cnt
  );

  modport slave (
    input  in_valid, opcode, rd, rs1, pc, imm, rs1_data, br_taken, out_ready,
    output in_ready, out_valid, jump, jtype, btype, aluop, exop, target,
           link_pc, ras_pred, ras_hit, ras_cnt, miss_cnt
  );
endinterface

// File: rtl/ysyx_22040931_ras.sv
// Circular return-address stack: push, pop, or pop-then-push (top replace).
// A push into a full stack overwrites the oldest entry.
module ysyx_22040931_ras #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [XLEN-1:0]            data_i,
  output logic [XLEN-1:0]            top_o,
  output logic [$clog2(DEPTH):0]     cnt_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [XLEN-1:0] mem_q [DEPTH];
  logic [PW-1:0]   ptr_q, ptr_d, top_idx, wr_idx;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            wr_en, empty;

  assign top_idx = ptr_q - PW'(1);
  assign empty   = (cnt_q == '0);
  assign top_o   = mem_q[top_idx];
  assign cnt_o   = cnt_q;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    ptr_d  = ptr_q;
    cnt_d  = cnt_q;
    wr_en  = 1'b0;
    wr_idx = ptr_q;
    if (pop_i && !empty) begin
      if (push_i) begin
        wr_en  = 1'b1;
        wr_idx = top_idx;
      end else begin
        ptr_d = top_idx;
        cnt_d = cnt_q - CW'(1);
      end
    end else if (push_i) begin
      wr_en = 1'b1;
      ptr_d = ptr_q + PW'(1);
      if (cnt_q != CW'(DEPTH)) cnt_d = cnt_q + CW'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  // NOTE: entries are not reset; cnt_q gates every read, so stale data is never used.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_idx] <= data_i;
  end

endmodule

// File: rtl/ysyx_22040931_jump_unit.sv
// Control-transfer unit: decodes jal/jalr/B-type into a registered result stage
// with valid/ready handshake, and predicts returns with a RAS.
module ysyx_22040931_jump_unit
  import ysyx_22040931_jump_unit_pkg::*;
#(
  parameter int XLEN      = 64,
  parameter int RAS_DEPTH = 4,
  parameter int CNT_W     = 16
) (
  input logic                      clk,
  input logic                      rst,
  ysyx_22040931_jump_unit_if.slave bus
);
  localparam int CW = $clog2(RAS_DEPTH) + 1;

  ctrl_t            ctrl_d, ctrl_q;
  logic [XLEN-1:0]  target_d, target_q, link_d, link_q, pred_d, pred_q, ras_top;
  logic             hit_d, hit_q, out_valid_q, fire;
  logic             is_jal, is_jalr, push, pop;
  logic [CNT_W-1:0] miss_d, miss_q;
  logic [CW-1:0]    ras_cnt;

  assign bus.in_ready = !out_valid_q || bus.out_ready;
  assign fire         = bus.in_valid && bus.in_ready;

  assign is_jal  = (bus.opcode == OP_JAL);
  assign is_jalr = (bus.opcode == OP_JALR);
  assign link_d  = bus.pc + XLEN'(4);

  always_comb begin
    ctrl_d   = '0;
    target_d = '0;
    case (bus.opcode)
      OP_JAL: begin
        ctrl_d.jump  = 1'b1;
        ctrl_d.jtype = 1'b1;
        ctrl_d.aluop = ALU_ARITH;
        ctrl_d.exop  = EX_JUMP;
        target_d     = bus.pc + bus.imm;
      end
      OP_JALR: begin
        ctrl_d.jump  = 1'b1;
        ctrl_d.aluop = ALU_ARITH;
        ctrl_d.exop  = EX_JUMP;
        target_d     = (bus.rs1_data + bus.imm) & ~XLEN'(1);
      end
      OP_BRANCH: begin
        ctrl_d.jump  = bus.br_taken;
        ctrl_d.btype = 1'b1;
        ctrl_d.aluop = ALU_ARITH;
        ctrl_d.exop  = EX_BRANCH;
        target_d     = bus.pc + bus.imm;
      end
      default: ;
    endcase
  end

  // Call = link rd; return = link rs1, unless rd names the same link register.
  assign push = fire && (is_jal || is_jalr) && is_link_reg(bus.rd);
  assign pop  = fire && is_jalr && is_link_reg(bus.rs1) &&
                !(is_link_reg(bus.rd) && (bus.rd == bus.rs1));

  assign hit_d  = pop && (ras_cnt != '0);
  assign pred_d = hit_d ? ras_top : '0;

  always_comb begin
    miss_d = miss_q;
    if (hit_d && (pred_d != target_d) && (miss_q != '1)) miss_d = miss_q + CNT_W'(1);
  end

  ysyx_22040931_ras #(
    .XLEN  (XLEN),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk    (clk),
    .rst    (rst),
    .push_i (push),
    .pop_i  (pop),
    .data_i (link_d),
    .top_o  (ras_top),
    .cnt_o  (ras_cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      ctrl_q      <= '0;
      target_q    <= '0;
      link_q      <= '0;
      pred_q      <= '0;
      hit_q       <= 1'b0;
      miss_q      <= '0;
    end else begin
      miss_q <= miss_d;
      if (fire) begin
        out_valid_q <= 1'b1;
        ctrl_q      <= ctrl_d;
        target_q    <= target_d;
        link_q      <= link_d;
        pred_q      <= pred_d;
        hit_q       <= hit_d;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.jump      = ctrl_q.jump;
  assign bus.jtype     = ctrl_q.jtype;
  assign bus.btype     = ctrl_q.btype;
  assign bus.aluop     = ctrl_q.aluop;
  assign bus.exop      = ctrl_q.exop;
  assign bus.target    = target_q;
  assign bus.link_pc   = link_q;
  assign bus.ras_pred  = pred_q;
  assign bus.ras_hit   = hit_q;
  assign bus.ras_cnt   = ras_cnt;
  assign bus.miss_cnt  = miss_q;

endmodule
